// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and priority-state encoding for the register-file write arbiter.
package regfile_write_arbiter_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_e;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant with a one-bit priority flop.
// Grants are combinational from req; reset forces both grants low.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  prio_e prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (reset) prio_q <= PRIO_ALU;
    else       prio_q <= prio_d;
  end

  always_comb begin
    gnt_alu_o = 1'b0;
    gnt_mem_o = 1'b0;
    prio_d    = prio_q;
    if (!reset) begin
      gnt_alu_o = req_alu_i && (!req_mem_i || prio_q == PRIO_ALU);
      gnt_mem_o = req_mem_i && (!req_alu_i || prio_q == PRIO_MEM);
    end
    // Priority passes to whoever lost (or did not ask) this cycle.
    if (gnt_alu_o)      prio_d = PRIO_MEM;
    else if (gnt_mem_o) prio_d = PRIO_ALU;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and memory writeback,
// with a registered write stage and a pending-write scoreboard for hazards.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_req,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ack,
  input  logic                mem_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ack,
  input  logic                busy_set,
  input  logic [ADDR_W-1:0]   busy_set_addr,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                rd_hazard1,
  output logic                rd_hazard2,
  output logic                rf_wr_en,
  output logic [ADDR_W-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic                gnt_alu, gnt_mem;
  logic                wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] busy_q,    busy_d;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_alu_i (alu_req),
    .req_mem_i (mem_req),
    .gnt_alu_o (gnt_alu),
    .gnt_mem_o (gnt_mem)
  );

  always_comb begin
    wr_en_d   = gnt_alu | gnt_mem;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_alu) begin
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (gnt_mem) begin
      wr_addr_d = mem_addr;
      wr_data_d = mem_data;
    end
  end

  // Set after clear: a set belongs to a newer instruction than the write retiring now.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)  busy_d[wr_addr_q]     = 1'b0;
    if (busy_set) busy_d[busy_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign alu_ack    = gnt_alu;
  assign mem_ack    = gnt_mem;
  assign rd_hazard1 = busy_q[rd_addr1];
  assign rd_hazard2 = busy_q[rd_addr2];
  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign busy_vec   = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table-driven bench for regfile_write_arbiter plus a same-address ordering sequence.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_req, mem_req, busy_set;
  logic [2:0]  alu_addr, mem_addr, busy_set_addr, rd_addr1, rd_addr2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ack, mem_ack, rd_hazard1, rd_hazard2, rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [7:0]  busy_vec;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_hazard1(rd_hazard1), .rd_hazard2(rd_hazard2),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy_vec(busy_vec)
  );

  typedef struct {
    logic        rst;
    logic        areq;  logic [2:0] aaddr; logic [31:0] adat;
    logic        mreq;  logic [2:0] maddr; logic [31:0] mdat;
    logic        bset;  logic [2:0] baddr;
    logic [2:0]  rd1;   logic [2:0] rd2;
    logic        e_aack, e_mack, e_en;
    logic [2:0]  e_addr; logic [31:0] e_dat; logic [7:0] e_busy;
    logic        e_h1, e_h2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst,
                     input logic areq, input logic [2:0] aaddr, input logic [31:0] adat,
                     input logic mreq, input logic [2:0] maddr, input logic [31:0] mdat,
                     input logic bset, input logic [2:0] baddr,
                     input logic [2:0] rd1, input logic [2:0] rd2,
                     input logic e_aack, input logic e_mack, input logic e_en,
                     input logic [2:0] e_addr, input logic [31:0] e_dat,
                     input logic [7:0] e_busy, input logic e_h1, input logic e_h2);
    vec_t v;
    v = '{rst, areq, aaddr, adat, mreq, maddr, mdat, bset, baddr, rd1, rd2,
          e_aack, e_mack, e_en, e_addr, e_dat, e_busy, e_h1, e_h2};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic rst, input logic areq, input logic [2:0] aaddr, input logic [31:0] adat,
                       input logic mreq, input logic [2:0] maddr, input logic [31:0] mdat,
                       input logic bset, input logic [2:0] baddr, input logic [2:0] rd1, input logic [2:0] rd2);
    reset = rst; alu_req = areq; alu_addr = aaddr; alu_data = adat;
    mem_req = mreq; mem_addr = maddr; mem_data = mdat;
    busy_set = bset; busy_set_addr = baddr; rd_addr1 = rd1; rd_addr2 = rd2;
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //   rst areq aa adat          mreq ma mdat          bs ba r1 r2 | aack mack en addr edat          busy  h1 h2
    add(1, 1, 0, 32'hACED_CAFE, 1, 7, 32'hFFFF_FFFF, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 1, 3, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 1, 3, 32'hDEAD_BEEF, 8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 3, 32'hDEAD_BEEF, 8'h00, 0, 0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 3, 32'hDEAD_BEEF, 8'h00, 0, 0);
    add(0, 1, 0, 32'hACED_CAFE, 1, 7, 32'hFFFF_FFFF, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 1, 0, 32'hACED_CAFE, 1, 7, 32'hFFFF_FFFF, 0, 0, 0, 0,  0, 1, 1, 0, 32'hACED_CAFE, 8'h00, 0, 0);
    add(0, 1, 0, 32'hACED_CAFE, 1, 7, 32'hFFFF_FFFF, 0, 0, 0, 0,  1, 0, 1, 7, 32'hFFFF_FFFF, 8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 1, 0, 32'hACED_CAFE, 8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 5, 5, 0,  0, 0, 0, 0, 32'hACED_CAFE, 8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         1, 5, 32'h1234_5678, 0, 0, 5, 0,  0, 1, 0, 0, 32'hACED_CAFE, 8'h20, 1, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 5, 0,  0, 0, 1, 5, 32'h1234_5678, 8'h20, 1, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 5, 0,  0, 0, 0, 5, 32'h1234_5678, 8'h00, 0, 0);
    add(0, 1, 2, 32'h0000_0002, 0, 0, 32'h0,         0, 0, 0, 2,  1, 0, 0, 5, 32'h1234_5678, 8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 0, 2,  0, 0, 1, 2, 32'h0000_0002, 8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 0, 2,  0, 0, 0, 2, 32'h0000_0002, 8'h04, 0, 1);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 6, 6, 2,  0, 0, 0, 2, 32'h0000_0002, 8'h04, 0, 1);
    add(0, 1, 1, 32'h1111_1111, 1, 4, 32'h4444_4444, 0, 0, 6, 2,  0, 1, 0, 2, 32'h0000_0002, 8'h44, 1, 1);
    add(1, 1, 1, 32'h1111_1111, 1, 4, 32'h4444_4444, 0, 0, 6, 2,  0, 0, 1, 4, 32'h4444_4444, 8'h44, 1, 1);
    add(0, 1, 1, 32'h1111_1111, 1, 4, 32'h4444_4444, 0, 0, 6, 2,  1, 0, 0, 0, 32'h0,         8'h00, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 1, 1, 32'h1111_1111, 8'h00, 0, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      drive(vecs[i].rst, vecs[i].areq, vecs[i].aaddr, vecs[i].adat,
            vecs[i].mreq, vecs[i].maddr, vecs[i].mdat,
            vecs[i].bset, vecs[i].baddr, vecs[i].rd1, vecs[i].rd2);
      @(negedge clk);
      check("alu_ack",    i, 32'(alu_ack),    32'(vecs[i].e_aack));
      check("mem_ack",    i, 32'(mem_ack),    32'(vecs[i].e_mack));
      check("rf_wr_en",   i, 32'(rf_wr_en),   32'(vecs[i].e_en));
      check("rf_wr_addr", i, 32'(rf_wr_addr), 32'(vecs[i].e_addr));
      check("rf_wr_data", i, rf_wr_data,      vecs[i].e_dat);
      check("busy_vec",   i, 32'(busy_vec),   32'(vecs[i].e_busy));
      check("rd_hazard1", i, 32'(rd_hazard1), 32'(vecs[i].e_h1));
      check("rd_hazard2", i, 32'(rd_hazard2), 32'(vecs[i].e_h2));
      @(posedge clk);
    end

    // Same destination from both sides: priority is MEM here, so MEM then ALU, ALU data is final.
    #1 drive(0, 1, 6, 32'hAAAA_0000, 1, 6, 32'hBBBB_0000, 0, 0, 0, 0);
    @(negedge clk);
    check("same_addr_mem_first", 100, 32'(mem_ack), 32'd1);
    check("same_addr_alu_wait",  100, 32'(alu_ack), 32'd0);
    @(posedge clk);
    #1 drive(0, 1, 6, 32'hAAAA_0000, 0, 0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    check("same_addr_alu_second", 101, 32'(alu_ack), 32'd1);
    check("same_addr_first_data", 101, rf_wr_data, 32'hBBBB_0000);
    @(posedge clk);
    #1 drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    check("same_addr_final_en",   102, 32'(rf_wr_en),   32'd1);
    check("same_addr_final_addr", 102, 32'(rf_wr_addr), 32'd6);
    check("same_addr_final_data", 102, rf_wr_data,      32'hAAAA_0000);
    @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x32 register file between two writeback requesters: ALU result and memory load.
- Fair round-robin arbitration with req/ack handshake and a registered write stage.
- Keeps an 8-bit scoreboard of registers with outstanding writes and flags read hazards on both register-file read addresses for the issue logic.
- Sits between the execute/memory stages and the register file write port (input data, input address, write enable).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_req  in  1  ALU requests a write; held with addr/data until alu_ack
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU write data
- alu_ack  out  1  combinational; high in the cycle the ALU request is accepted
- mem_req  in  1  memory requests a write; same rules as alu_req
- mem_addr  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  memory write data
- mem_ack  out  1  combinational accept for memory
- busy_set  in  1  issue logic marks a register as pending a write
- busy_set_addr  in  ADDR_W  register to mark
- rd_addr1  in  ADDR_W  register-file read address 1
- rd_addr2  in  ADDR_W  register-file read address 2
- rd_hazard1  out  1  combinational: busy_vec[rd_addr1]
- rd_hazard2  out  1  combinational: busy_vec[rd_addr2]
- rf_wr_en  out  1  registered write enable to register file
- rf_wr_addr  out  ADDR_W  registered write address
- rf_wr_data  out  DATA_W  registered write data
- busy_vec  out  NUM_REGS  scoreboard, bit i = register i has a pending write

Behaviour:
- Reset values: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, busy_vec=0, priority state=PRIO_ALU.
- Reset also forces alu_ack and mem_ack low during reset cycles.
- Priority FSM, two states: PRIO_ALU and PRIO_MEM.
  - Only one requester active: it wins regardless of state.
  - Both active: the requester named by the state wins.
  - After any grant, the state moves to the non-granted requester's priority. With no grant, the state holds.
- At most one ack per cycle. Acks are never asserted without the matching req.
- Latency: a grant in cycle N drives rf_wr_en=1 with the granted addr/data in cycle N+1. The write commits at the register file on the edge ending N+1.
  - With no grant in N, rf_wr_en=0 in N+1.
  - rf_wr_addr and rf_wr_data hold their last values when idle.
- Throughput: one write per cycle. Back-to-back grants are allowed, alternating under contention.
- A requester keeps req/addr/data stable until ack. It may present a new request in the cycle after ack.
- Scoreboard, updated on each edge:
  - When rf_wr_en=1, busy_vec[rf_wr_addr] clears.
  - When busy_set=1, busy_vec[busy_set_addr] sets.
  - Same address set and cleared in one cycle: set wins, because it belongs to a newer instruction.
  - Clearing an already-clear bit and setting an already-set bit are both harmless no-ops.
- Hazards reflect busy_vec only (no bypass). A read of the register being written in the same cycle still reports a hazard until the following cycle.
- Both requesters targeting the same address: writes are serialized in grant order, so the last grant's data is final.
- Reset mid-operation: an in-flight registered write is dropped (rf_wr_en=0 next cycle) and all pending bits are cleared.

Decomposition:
- Shared package holds DATA_W/ADDR_W/NUM_REGS defaults and the priority-state encoding (PRIO_ALU=0, PRIO_MEM=1).
- One natural sub-module, rr_arbiter2: the two-requester round-robin grant logic plus its priority flop.
- Scoreboard and output register stay in the top.

Test Plan:
- Reset, then idle for 3 cycles -> rf_wr_en=0, busy_vec=8'h00, rd_hazard1/2=0, both acks 0.
- alu_req with addr=3'b011, data=32'hDEAD_BEEF alone -> alu_ack in cycle N; cycle N+1 shows rf_wr_en=1, rf_wr_addr=3, rf_wr_data=32'hDEAD_BEEF; cycle N+2 shows rf_wr_en=0.
- Both requests held continuously (ALU addr 0 data 32'hACED_CAFE, MEM addr 7 data 32'hFFFF_FFFF) from reset -> grant order ALU, MEM; writes appear on consecutive cycles; each ack pulses once.
- busy_set addr 5, then rd_addr1=5 -> busy_vec[5]=1 and rd_hazard1=1; after a MEM write to addr 5 commits -> busy_vec[5]=0 and rd_hazard1=0.
- busy_set addr 2 in the same cycle rf_wr_en=1, rf_wr_addr=2 -> busy_vec[2] remains 1.
- Grant issued, then reset asserted in the next cycle -> rf_wr_en=0, busy_vec=0, and the next contended grant goes to ALU.
